lzc_norm_pipe: RTL
==================

Name: lzc_norm_pipe

Overview:
- Parametrised, pipelined leading-zero counter and normaliser for the FP multiplier datapath.
- Accepts a WIDTH-bit mantissa/product word, splits it into SEG-bit segments, and counts leading zeros per segment in stage 1.
- Stage 2 combines the segment counts by priority, left-shifts the word so its MSB is 1, and presents the count, the normalised word and a zero flag.
- valid/ready on both sides; 2-cycle latency; full throughput.

Parameters:
- WIDTH, 32, input word width; power of two, >= 2*SEG.
- SEG, 8, segment width for the first-stage counters; power of two, >= 2.
- TAG_W, 4, width of the sideband tag carried alongside the data.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept this cycle.
- in_data  in  WIDTH  word to count; MSB is in_data[WIDTH-1].
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_z  out  $clog2(WIDTH)  leading-zero count; 0 when the word is zero.
- out_zero  out  1  1 when the captured word was all zero.
- out_norm  out  WIDTH  in_data << out_z, zero-filled; all zero when out_zero.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset (async assert, sync release):
  - s1_valid=0, s2_valid=0.
  - out_valid=0, out_z=0, out_zero=0, out_norm=0, out_tag=0.
  - in_ready=1 as soon as reset deasserts.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage 1 registers, per transfer:
  - in_data and in_tag.
  - NSEG=WIDTH/SEG segment counts, each $clog2(SEG) bits; segment 0 holds the MSBs.
  - NSEG segment-nonzero flags.
- Stage 2 registers:
  - k = index of the first nonzero segment.
  - out_z = k*SEG + zcnt[k].
  - out_zero = no segment nonzero.
  - out_norm = data << out_z.
  - out_tag.
- Stall rules:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1. This is combinational from out_ready; no combinational path from in_valid.
- Data hold: while out_valid && !out_ready, all out_* hold stable. Stage 1 also holds if full.
- Latency and throughput:
  - Result for an input accepted in cycle N is valid in cycle N+2 with no stall.
  - Back-to-back inputs give one result per cycle.
- Bubbles: if stage 1 is empty and stage 2 drains, s2_valid clears. out_* data may keep its old value; it is don't-care while out_valid=0.
- Ordering: results leave in order; no drops or duplicates under any in_valid/out_ready pattern.
- Simultaneous accept and drain in one cycle is legal at both stages.
- Reset mid-operation: in-flight words are discarded; no result is produced after rst_n rises.
- Combine logic: pure priority on segment flags. Sums fit in $clog2(WIDTH) bits because max is WIDTH-1.

Optional Feature:
- Macro: LZC_PERF_EN.
- With the macro, extra ports:
  - perf_xfers  out  16  saturating count of output transfers.
  - perf_stalls  out  16  saturating count of cycles with out_valid && !out_ready.
  - perf_clr  in  1  synchronous clear.
- Counter rules:
  - Both counters reset to 0 on rst_n.
  - perf_clr wins over an increment in the same cycle.
  - Counters saturate at 16'hFFFF.
- Without the macro: ports absent, no counters; behaviour otherwise identical.

Test Plan:
- WIDTH=32, out_ready=1; feed 0x80000000, 0x00010000, 0x00000001, 0x00000000 back-to-back:
  - outputs in cycles N+2..N+5.
  - out_z = 0, 15, 31, 0.
  - out_zero = 0, 0, 0, 1.
  - out_norm = 0x80000000 ×3, then 0.
- Walking one: 0x1<<i for i=0..31, random tags -> out_z=31-i, out_norm=0x80000000, tag preserved.
- Backpressure: stream 8 words, hold out_ready=0 for 5 cycles mid-stream:
  - in_ready drops after 2 more accepts.
  - out_* hold stable.
  - all 8 results arrive in order.
- Random in_valid/out_ready at 50%, 10k words, checked against a reference model -> no loss, duplication or reorder.
- Assert rst_n=0 with both stages full -> out_valid=0 immediately, all outputs 0; no stale result after release.
- LZC_PERF_EN: 10 transfers, 3 stall cycles -> perf_xfers=10, perf_stalls=3; pulse perf_clr -> both 0 the next cycle.

Source files
------------

// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage pipelined leading-zero counter and normaliser for
// the FP multiplier datapath.
//
// Stage 1 splits the word into NSEG = WIDTH/SEG segments (segment 0 = MSBs).
// For each segment it registers a leading-zero count and a nonzero flag,
// together with the word and its tag.
// Stage 2 picks the first nonzero segment k by priority and forms
// z = k*SEG + cnt[k]. It then registers z, the zero flag, data << z and the tag.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   input handshake; in_ready depends only on pipeline
//                       state and out_ready, never on in_valid
//   in_data, in_tag     word to count (MSB = in_data[WIDTH-1]) and sideband
//   out_valid/out_ready output handshake
//   out_z               leading-zero count, 0 for an all-zero word
//   out_zero            captured word was all zero
//   out_norm            in_data << out_z, zero-filled
//   out_tag             sideband of this result
//
// Optional build macro LZC_PERF_EN adds three ports:
//   perf_clr    (in)  synchronous clear of both counters; wins over increment
//   perf_xfers  (out) saturating count of output transfers
//   perf_stalls (out) saturating count of cycles with out_valid && !out_ready
//
// WIDTH and SEG must be powers of two with WIDTH >= 2*SEG and SEG >= 2.

// Per-segment leading-zero counter. Its count is meaningless when nz = 0;
// the combine stage ignores it in that case.
module lzc_seg #(
    parameter int SEG = 8,
    parameter int SW  = $clog2(SEG)
) (
    input  logic [SEG-1:0] seg,
    output logic [SW-1:0]  cnt,
    output logic           nz
);
    always_comb begin
        cnt = '0;
        // Scan LSB to MSB so that the highest set bit is the last to write cnt.
        for (int i = 0; i < SEG; i++) begin
            if (seg[i]) cnt = SW'(SEG - 1 - i);
        end
    end

    assign nz = |seg;
endmodule

module lzc_norm_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef LZC_PERF_EN
    input  logic                       perf_clr,
    output logic [15:0]                perf_xfers,
    output logic [15:0]                perf_stalls,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH)-1:0]   out_z,
    output logic                       out_zero,
    output logic [WIDTH-1:0]           out_norm,
    output logic [TAG_W-1:0]           out_tag
);
    localparam int NSEG = WIDTH / SEG;
    localparam int SW   = $clog2(SEG);
    localparam int ZW   = $clog2(WIDTH);

    // Segment counters, combinational on the incoming word.
    logic [NSEG-1:0][SW-1:0] seg_cnt;
    logic [NSEG-1:0]         seg_nz;

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        lzc_seg #(.SEG(SEG), .SW(SW)) u_seg (
            .seg (in_data[WIDTH-1-g*SEG -: SEG]),
            .cnt (seg_cnt[g]),
            .nz  (seg_nz[g])
        );
    end

    // Stage 1 state.
    logic                    s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]        s1_data_q,  s1_data_d;
    logic [TAG_W-1:0]        s1_tag_q,   s1_tag_d;
    logic [NSEG-1:0][SW-1:0] s1_zcnt_q,  s1_zcnt_d;
    logic [NSEG-1:0]         s1_nz_q,    s1_nz_d;

    // Stage 2 state, which drives the outputs directly.
    logic                    s2_valid_q, s2_valid_d;
    logic [ZW-1:0]           s2_z_q,     s2_z_d;
    logic                    s2_zero_q,  s2_zero_d;
    logic [WIDTH-1:0]        s2_norm_q,  s2_norm_d;
    logic [TAG_W-1:0]        s2_tag_q,   s2_tag_d;

    logic adv1, adv2, acc1, ld2;
    logic [ZW-1:0] comb_z;

    // Handshake. A stage advances when it is empty or the stage after it
    // advances, so a full pipeline can accept and drain in the same cycle.
    always_comb begin
        adv2 = !s2_valid_q || out_ready;
        adv1 = !s1_valid_q || adv2;
        acc1 = in_valid && adv1;
        ld2  = adv2 && s1_valid_q;
    end

    assign in_ready = adv1;

    // Stage 1 next state.
    always_comb begin
        s1_valid_d = adv1 ? in_valid : s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_tag_d   = s1_tag_q;
        s1_zcnt_d  = s1_zcnt_q;
        s1_nz_d    = s1_nz_q;
        if (acc1) begin
            s1_data_d = in_data;
            s1_tag_d  = in_tag;
            s1_zcnt_d = seg_cnt;
            s1_nz_d   = seg_nz;
        end
    end

    // Priority combine. Scanning from the last segment down to segment 0
    // leaves the first nonzero segment's value in comb_z. The maximum result
    // is WIDTH-1, so it fits in ZW bits.
    always_comb begin
        comb_z = '0;
        for (int i = NSEG - 1; i >= 0; i--) begin
            if (s1_nz_q[i]) comb_z = ZW'(i * SEG) + ZW'(s1_zcnt_q[i]);
        end
    end

    // Stage 2 next state. The output registers change only when a new word
    // loads, which keeps them stable for the whole of a stall.
    always_comb begin
        s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
        s2_z_d     = s2_z_q;
        s2_zero_d  = s2_zero_q;
        s2_norm_d  = s2_norm_q;
        s2_tag_d   = s2_tag_q;
        if (ld2) begin
            s2_z_d    = comb_z;
            s2_zero_d = ~|s1_nz_q;
            // An all-zero word has comb_z = 0, so the shift still gives zero.
            s2_norm_d = s1_data_q << comb_z;
            s2_tag_d  = s1_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s1_zcnt_q  <= '0;
            s1_nz_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_z_q     <= '0;
            s2_zero_q  <= 1'b0;
            s2_norm_q  <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_tag_q   <= s1_tag_d;
            s1_zcnt_q  <= s1_zcnt_d;
            s1_nz_q    <= s1_nz_d;
            s2_valid_q <= s2_valid_d;
            s2_z_q     <= s2_z_d;
            s2_zero_q  <= s2_zero_d;
            s2_norm_q  <= s2_norm_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_z     = s2_z_q;
    assign out_zero  = s2_zero_q;
    assign out_norm  = s2_norm_q;
    assign out_tag   = s2_tag_q;

`ifdef LZC_PERF_EN
    logic [15:0] perf_xfers_q,  perf_xfers_d;
    logic [15:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_xfers_d  = perf_xfers_q;
        perf_stalls_d = perf_stalls_q;
        if (perf_clr) begin
            perf_xfers_d  = '0;
            perf_stalls_d = '0;
        end else begin
            if (s2_valid_q && out_ready && perf_xfers_q != 16'hFFFF)
                perf_xfers_d = perf_xfers_q + 16'd1;
            if (s2_valid_q && !out_ready && perf_stalls_q != 16'hFFFF)
                perf_stalls_d = perf_stalls_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_xfers_q  <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_xfers_q  <= perf_xfers_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_xfers  = perf_xfers_q;
    assign perf_stalls = perf_stalls_q;
`endif
endmodule
